// File: rtl/switch_debounce3.sv
// Three-channel switch debouncer: 2-flop synchroniser plus per-channel stability FSM.
// Optional registered edge pulses on rise/fall when SWITCH_DEBOUNCE3_EDGE_EN is defined.
module switch_debounce3 #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter logic [2:0]  RESET_VAL     = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic [2:0] rise,
  output logic [2:0] fall
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  logic [2:0] s1_q, s2_q;
  logic [2:0] out_q, out_d;
  logic [2:0] pend_d;
  logic       busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= RESET_VAL;
      s2_q   <= RESET_VAL;
      out_q  <= RESET_VAL;
      busy_q <= 1'b0;
    end else begin
      s1_q   <= raw_in;
      s2_q   <= s1_q;
      out_q  <= out_d;
      busy_q <= |pend_d;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_nx;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_nx  = out_q[g];
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (s2_q[g] != out_q[g]) begin
            // A single required sample means the first differing sample commits.
            if (SINGLE) begin
              out_nx = ~out_q[g];
            end else begin
              state_d = ST_PENDING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_PENDING: begin
          if (s2_q[g] == out_q[g]) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            out_nx  = ~out_q[g];
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign out_d[g]  = out_nx;
    assign pend_d[g] = (state_d == ST_PENDING);
  end

  assign a_out = out_q[2];
  assign b_out = out_q[1];
  assign c_out = out_q[0];
  assign busy  = busy_q;

`ifdef SWITCH_DEBOUNCE3_EDGE_EN
  logic [2:0] rise_q, fall_q;

  // Pulses align with the edge on which the output itself changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_switch_debounce3.sv
// Directed self-checking bench for switch_debounce3 (STABLE_CYCLES=4 and =1 instances).
module tb_switch_debounce3;

`ifdef SWITCH_DEBOUNCE3_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw_in = 3'b000;
  logic       a_out, b_out, c_out, busy;
  logic [2:0] rise, fall;

  logic [2:0] raw_fast = 3'b000;
  logic       fa, fb, fc, fbusy;
  logic [2:0] frise, ffall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  switch_debounce3 #(.CNT_W(16), .STABLE_CYCLES(4), .RESET_VAL(3'b000)) u_dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out),
    .busy(busy), .rise(rise), .fall(fall)
  );

  switch_debounce3 #(.CNT_W(16), .STABLE_CYCLES(1), .RESET_VAL(3'b000)) u_fast (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_fast),
    .a_out(fa), .b_out(fb), .c_out(fc),
    .busy(fbusy), .rise(frise), .fall(ffall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    raw_in = 3'b000;
    rst_n  = 1'b0;
    tick();
    tests++;
    if ({a_out, b_out, c_out, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_hold: got out=%b busy=%b want out=000 busy=0", {a_out, b_out, c_out}, busy);
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      obs = {a_out, b_out, c_out, busy, rise, fall, 2'b00};
      tests++;
      if (obs !== 12'h000) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: got out=%b busy=%b rise=%b fall=%b want all zero",
                 t, {a_out, b_out, c_out}, busy, rise, fall);
      end
    end
  endtask

  task automatic test_latency();
    logic [2:0] eo, er;
    logic       eb;
    raw_in = 3'b011;
    for (int t = 1; t <= 7; t++) begin
      tick();
      eo = (t >= 6) ? 3'b011 : 3'b000;
      eb = (t >= 3 && t <= 5);
      er = (EDGE && t == 6) ? 3'b011 : 3'b000;
      tests++;
      if ({a_out, b_out, c_out} !== eo || busy !== eb || rise !== er || fall !== 3'b000) begin
        fails++;
        $display("FAIL latency t%0d: got out=%b busy=%b rise=%b fall=%b want out=%b busy=%b rise=%b fall=000",
                 t, {a_out, b_out, c_out}, busy, rise, fall, eo, eb, er);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b00110011;
    for (int i = 0; i < 8; i++) begin
      raw_in = {pat[i], 2'b11};
      tick();
      tests++;
      if ({a_out, b_out, c_out} !== 3'b011) begin
        fails++;
        $display("FAIL bounce step%0d: got out=%b want 011", i, {a_out, b_out, c_out});
      end
    end
    raw_in = 3'b111;
    for (int t = 1; t <= 6; t++) begin
      tick();
      tests++;
      if (a_out !== (t == 6)) begin
        fails++;
        $display("FAIL bounce_hold t%0d: got a_out=%b want %b", t, a_out, (t == 6));
      end
    end
  endtask

  task automatic test_reset_midcount();
    int hit;
    rst_n = 1'b0;
    #2;
    raw_in = 3'b100;
    rst_n  = 1'b1;
    hit = 0;
    for (int t = 1; t <= 10 && hit == 0; t++) begin
      tick();
      if (a_out === 1'b1) hit = t;
    end
    tests++;
    if (hit != 6) begin
      fails++;
      $display("FAIL rise_wait: got a_out high at tick %0d want tick 6", hit);
    end
    raw_in = 3'b000;
    tick();
    tick();
    tick();
    tests++;
    if (busy !== 1'b1 || a_out !== 1'b1) begin
      fails++;
      $display("FAIL midcount: got a_out=%b busy=%b want a_out=1 busy=1", a_out, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a_out, b_out, c_out, busy} !== 4'b0000 || rise !== 3'b000 || fall !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: got out=%b busy=%b rise=%b fall=%b want 000/0/000/000",
               {a_out, b_out, c_out}, busy, rise, fall);
    end
    raw_in = 3'b100;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      tests++;
      if (a_out !== (t == 6)) begin
        fails++;
        $display("FAIL post_reset t%0d: got a_out=%b want %b", t, a_out, (t == 6));
      end
    end
  endtask

  task automatic test_fall();
    logic [2:0] ef;
    raw_in = 3'b000;
    for (int t = 1; t <= 7; t++) begin
      tick();
      ef = (EDGE && t == 6) ? 3'b100 : 3'b000;
      tests++;
      if (a_out !== (t < 6) || fall !== ef || rise !== 3'b000) begin
        fails++;
        $display("FAIL fall t%0d: got a_out=%b rise=%b fall=%b want a_out=%b rise=000 fall=%b",
                 t, a_out, rise, fall, (t < 6), ef);
      end
    end
  endtask

  task automatic test_single_cycle();
    logic [2:0] eo;
    raw_fast = 3'b111;
    for (int t = 1; t <= 4; t++) begin
      tick();
      eo = (t >= 3) ? 3'b111 : 3'b000;
      tests++;
      if ({fa, fb, fc} !== eo || fbusy !== 1'b0) begin
        fails++;
        $display("FAIL single t%0d: got out=%b busy=%b want out=%b busy=0", t, {fa, fb, fc}, fbusy, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_reset_midcount();
    test_fall();
    test_single_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_debounce3.md
Name: switch_debounce3

Overview:
- Three-channel input conditioning stage that sits directly upstream of the A/B/C inputs of simple_circuit2.
- Takes raw, asynchronous, bouncy switch levels and synchronises each into the clk domain.
- Releases a new level on a channel only after it has been stable for a programmable number of cycles.
- Outputs are clean, glitch-free registered levels, so the downstream AND/OR logic never sees bounce.

Parameters:
- CNT_W, 16: width of each per-channel stability counter.
- STABLE_CYCLES, 1000: consecutive synchronised samples required before a channel output changes. Legal range is 1 to 2^CNT_W-1; the bench must not use values outside it.
- RESET_VAL, 3'b000: value loaded into the synchroniser flops and outputs at reset. Bit 2 is A, bit 1 is B, bit 0 is C.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; the block is held in reset while low.
- raw_in  input  3  raw switch levels {A,B,C}; asynchronous to clk.
- a_out  output  1  debounced A, feeds simple_circuit2 A.
- b_out  output  1  debounced B, feeds simple_circuit2 B.
- c_out  output  1  debounced C, feeds simple_circuit2 C.
- busy  output  1  high while any channel is in PENDING.
- rise  output  3  one-cycle rising-edge pulses, per channel (see Optional Feature).
- fall  output  3  one-cycle falling-edge pulses, per channel (see Optional Feature).

Behaviour:
- Reset, asynchronous on rst_n low:
  - both synchroniser stages load RESET_VAL;
  - outputs {a_out,b_out,c_out} load RESET_VAL;
  - all counters load 0, all channel FSMs go to STABLE;
  - busy, rise and fall load 0.
- Reset deassertion is assumed synchronised externally. The first active edge after rst_n rises performs normal sampling.
- Synchroniser: two flops per channel, raw_in to s1 to s2. Only s2 is used by the debounce logic. raw_in is never used combinationally.
- Per-channel FSM, two states. Let out be the channel's registered output.
  - STABLE, s2 == out: stay; counter = 0.
  - STABLE, s2 != out, STABLE_CYCLES == 1: toggle out on this edge; stay in STABLE; counter = 0.
  - STABLE, s2 != out, STABLE_CYCLES > 1: go to PENDING; counter = 1.
  - PENDING, s2 == out (bounce back): go to STABLE; counter = 0; out unchanged.
  - PENDING, s2 != out, counter == STABLE_CYCLES-1: toggle out; go to STABLE; counter = 0.
  - PENDING, s2 != out, otherwise: counter += 1. Never wraps, because it is bounded by STABLE_CYCLES-1.
- Latency: a raw level meeting setup before edge k, and held, changes the output at edge k+STABLE_CYCLES+1.
  - 2 edges are for synchronisation, overlapped with the first counted sample.
  - Any bounce back to the old level restarts the count from zero.
- Channels are fully independent. Simultaneous changes on several channels are each timed separately. Outputs may update on the same edge.
- busy is registered: the OR of all channels' next-state == PENDING.
- Reset asserted mid-count aborts the count immediately. No partial change is ever output.
- Outputs change only on clk edges or on reset, and are never combinational from raw_in.

Optional Feature:
- Macro: SWITCH_DEBOUNCE3_EDGE_EN.
- Defined:
  - rise[i] pulses high for exactly one cycle, registered, on the edge where output i goes 0->1.
  - fall[i] does the same for 1->0.
  - Both reset to 0; rise and fall never assert together for one channel.
- Not defined: rise and fall are tied to 3'b000 and no edge-detect flops are generated. The port list is unchanged.

Test Plan (STABLE_CYCLES=4, RESET_VAL=3'b000):
- Reset release with raw_in=000 held for 20 cycles -> outputs 000, busy=0, rise=fall=000 throughout.
- raw_in set to 011 before edge k and held -> b_out and c_out rise at edge k+5, a_out stays 0. busy is high from edge k+2 through k+4. With the macro, rise=011 for one cycle after edge k+5.
- raw_in[2] toggles 0,1,0,1 every 2 cycles, then holds 1 from edge k -> a_out stays 0 during the toggling and goes to 1 at edge k+5 only.
- raw_in=100 held until a_out=1, then rst_n pulsed low mid-count of a falling transition -> all outputs 000 immediately, busy=0. After release, a_out=1 again 5 edges after sampling resumes.
- Parameter override STABLE_CYCLES=1, raw_in 000->111 before edge k -> all outputs 1 at edge k+2, busy never asserts.
- Macro undefined, repeat scenario 2 -> outputs identical, rise and fall constantly 000.
